nrs_gold_seq: RTL and testbench
===============================

# nrs_gold_seq

Downstream of the NRS cinit generator. On each accepted `cinit` it runs the length-31 Gold sequence generator of 36.211 §7.2 (Nc = 1600) and returns the four c(n) bits the NRS mapper needs: c(218..221), i.e. index m' = m + 109 for m = 0,1. A one-deep pending register absorbs the generator's back-to-back l=5 / l=6 requests so that neither is lost.

## Interface
- `STEPS`, 1: LFSR steps per clock. Legal values are 1, 2, 3, 6, 9, 18, all divisors of 1818. Any other value is an elaboration error.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cinit`  in  28  x2 initial state; bits [30:28] of x2 are loaded as 0.
- `cinit_valid`  in  1  request strobe, sampled every edge.
- `c_bits`  out  4  bit k = c(218+k).
- `c_valid`  out  1  one-cycle pulse qualifying `c_bits`.
- `busy`  out  1  LFSRs are advancing.
- `pend_full`  out  1  pending register is occupied.
- `overflow`  out  1  one-cycle pulse: a request was dropped.

## Operation
- States are IDLE and RUN.
- Accept in IDLE: a `cinit_valid` edge loads x1 = 31'h1 and x2 = {3'b0, cinit}, clears the step counter and enters RUN.
- In RUN, each edge advances both LFSRs by `STEPS` steps:
  - x1(n+31) = x1(n+3) ^ x1(n)
  - x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n)
  - The multi-step update is unrolled combinationally.
- The counter is 11 bits and counts edges. After 1818/STEPS edges the windows hold x(1818..1848).
- Completion is the edge on which the last step is applied. On that edge the block also registers `c_bits[k] = x1new[k] ^ x2new[k]` for k = 0..3 and sets `c_valid` = 1 for the following cycle.
- `cinit_valid` while RUN and pending empty: `cinit` is stored in pending and `pend_full` is set.
- `cinit_valid` while RUN and pending full: the request is dropped and `overflow` pulses. Pending keeps its old value.
- On the completion edge:
  - If pending is full, its value is loaded, pending is cleared and the block stays in RUN. There are no idle cycles between runs.
  - Otherwise the block returns to IDLE.
- Simultaneous events on the completion edge:
  - pending full + `cinit_valid`: pending is consumed and the new `cinit` is written into pending. No overflow.
  - pending empty + `cinit_valid`: the new `cinit` loads directly and the block stays in RUN.
- Reset mid-run: the run is abandoned, pending is discarded and no `c_valid` follows.
- Reset values: `c_bits` = 0, `c_valid` = 0, `busy` = 0, `pend_full` = 0, `overflow` = 0. State is IDLE, the counter is 0 and both LFSRs are 0.

## Timing
- Accept edge E, then 1818/STEPS advance edges. `c_valid` is high in the cycle after edge E + 1818/STEPS.
- Latency examples:
  - STEPS=1: `c_valid` high in cycle E+1819.
  - STEPS=18: `c_valid` high in cycle E+102.
- `busy` is high from the cycle after E through the cycle that ends with the completion edge. It stays high continuously across back-to-back runs.
- `c_bits` holds its value until the next completion edge.
- No backpressure on the output. The consumer must take `c_bits` while `c_valid` is high.
- Throughput is one result per 1818/STEPS cycles.

## Configuration
- `NRS_GOLD_QPSK_OUT_EN` defined: adds outputs `re0_i`, `re0_q`, `re1_i`, `re1_q`, each 2-bit signed.
  - Value = 1 − 2·c, so a bit of 0 gives 2'b01 and a bit of 1 gives 2'b11.
  - Source bits: re0 uses c(218), c(219); re1 uses c(220), c(221).
  - Registered alongside `c_bits` and valid under `c_valid`. Reset value is 2'b01.
- Undefined: those ports and registers do not exist. `c_bits` behaviour is unchanged.

## Structure
- Shared package `nrs_pkg`:
  - `NC` = 1600
  - `M_OFFSET` = 218
  - `WARMUP` = 1818
  - `LFSR_W` = 31
  - `CINIT_W` = 28
  - the IDLE/RUN state enum
- One sub-module, `gold_lfsr_step`: combinational, parameterised by `STEPS`. It maps (x1, x2) to their values advanced by `STEPS` steps and is instantiated once.

## Test plan
- cinit = 13313 (cell 0, slot 0, l 5), STEPS=1, single request -> `c_valid` high only in cycle E+1819. `c_bits` equals the 36.211 C model's c(218..221). `busy` is high for exactly 1818 cycles.
- Same cinit with STEPS=1 and STEPS=18 -> identical `c_bits`. Latencies are 1819 and 102 cycles respectively.
- Requests 13313 then 14337 (l 6) on consecutive edges -> second request lands in pending. Two `c_valid` pulses 1818/STEPS cycles apart, `busy` never drops, each result matches the C model.
- Three requests on consecutive edges -> exactly one `overflow` pulse, on the third edge. Two results are produced; the third cinit is never processed.
- `cinit_valid` asserted exactly on a completion edge with pending full -> pending is consumed, the new cinit is stored, no `overflow`, three results in order.
- `rst` asserted at cycle E+900 of a run with pending full -> all outputs 0 on the next edge. No `c_valid` appears within 2000 cycles. A fresh request afterwards gives the correct result.

Source files
------------

// File: rtl/nrs_pkg.sv
// Shared constants, state enum and helpers for the NRS Gold sequence block.
// Optional QPSK outputs are enabled by NRS_GOLD_QPSK_OUT_EN in nrs_gold_seq.
package nrs_pkg;

    localparam int NC       = 1600;
    localparam int M_OFFSET = 218;
    localparam int WARMUP   = NC + M_OFFSET;
    localparam int LFSR_W   = 31;
    localparam int CINIT_W  = 28;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // 1 - 2c as a 2-bit signed value: 0 -> +1, 1 -> -1
    function automatic logic [1:0] qpsk_map(input logic c);
        return {c, 1'b1};
    endfunction

endpackage

// File: rtl/gold_lfsr_step.sv
// Advances the x1/x2 Gold LFSR windows by STEPS steps combinationally.
// Bit i of each window holds x(n+i).
module gold_lfsr_step
    import nrs_pkg::*;
#(
    parameter int STEPS = 1
) (
    input  logic [LFSR_W-1:0] x1_i,
    input  logic [LFSR_W-1:0] x2_i,
    output logic [LFSR_W-1:0] x1_o,
    output logic [LFSR_W-1:0] x2_o
);

    logic [LFSR_W-1:0] a;
    logic [LFSR_W-1:0] b;

    always_comb begin
        a = x1_i;
        b = x2_i;
        for (int s = 0; s < STEPS; s++) begin
            a = {a[3] ^ a[0], a[LFSR_W-1:1]};
            b = {b[3] ^ b[2] ^ b[1] ^ b[0], b[LFSR_W-1:1]};
        end
        x1_o = a;
        x2_o = b;
    end

endmodule

// File: rtl/nrs_gold_seq.sv
// NRS Gold sequence: returns c(218..221) per accepted cinit, with one pending slot.
// Define NRS_GOLD_QPSK_OUT_EN to add the registered QPSK symbol outputs.
module nrs_gold_seq
    import nrs_pkg::*;
#(
    parameter int STEPS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CINIT_W-1:0] cinit,
    input  logic               cinit_valid,
    output logic [3:0]         c_bits,
    output logic               c_valid,
    output logic               busy,
    output logic               pend_full,
`ifdef NRS_GOLD_QPSK_OUT_EN
    output logic [1:0]         re0_i,
    output logic [1:0]         re0_q,
    output logic [1:0]         re1_i,
    output logic [1:0]         re1_q,
`endif
    output logic               overflow
);

    generate
        if (!(STEPS == 1 || STEPS == 2 || STEPS == 3 ||
              STEPS == 6 || STEPS == 9 || STEPS == 18)) begin : g_bad_steps
            $error("nrs_gold_seq: STEPS must divide 1818");
        end
    endgenerate

    localparam int          RUN_EDGES = WARMUP / STEPS;
    localparam logic [10:0] LAST      = 11'(RUN_EDGES - 1);
    localparam logic [LFSR_W-1:0] X1_INIT = LFSR_W'(1);

    state_e              state_q, state_d;
    logic [10:0]         cnt_q, cnt_d;
    logic [LFSR_W-1:0]   x1_q, x1_d, x2_q, x2_d;
    logic [LFSR_W-1:0]   x1_nx, x2_nx;
    logic [CINIT_W-1:0]  pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [3:0]          c_bits_q, c_bits_d;
    logic                c_valid_q, c_valid_d;
    logic                overflow_q, overflow_d;

    gold_lfsr_step #(.STEPS(STEPS)) u_step (
        .x1_i (x1_q),
        .x2_i (x2_q),
        .x1_o (x1_nx),
        .x2_o (x2_nx)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        c_bits_d    = c_bits_q;
        c_valid_d   = 1'b0;
        overflow_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cinit_valid) begin
                    x1_d    = X1_INIT;
                    x2_d    = {3'b000, cinit};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x1_d  = x1_nx;
                x2_d  = x2_nx;
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == LAST) begin
                    c_bits_d  = x1_nx[3:0] ^ x2_nx[3:0];
                    c_valid_d = 1'b1;
                    cnt_d     = '0;
                    if (pend_full_q) begin
                        // Chain straight into the pending run; refill if a
                        // request arrives on this same edge.
                        x1_d        = X1_INIT;
                        x2_d        = {3'b000, pend_q};
                        pend_full_d = cinit_valid;
                        if (cinit_valid) pend_d = cinit;
                    end else if (cinit_valid) begin
                        x1_d = X1_INIT;
                        x2_d = {3'b000, cinit};
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cinit_valid) begin
                    if (!pend_full_q) begin
                        pend_d      = cinit;
                        pend_full_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            c_bits_q    <= '0;
            c_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            c_bits_q    <= c_bits_d;
            c_valid_q   <= c_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign c_bits    = c_bits_q;
    assign c_valid   = c_valid_q;
    assign busy      = (state_q == RUN);
    assign pend_full = pend_full_q;
    assign overflow  = overflow_q;

`ifdef NRS_GOLD_QPSK_OUT_EN
    logic [1:0] re0_i_q, re0_q_q, re1_i_q, re1_q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            re0_i_q <= 2'b01;
            re0_q_q <= 2'b01;
            re1_i_q <= 2'b01;
            re1_q_q <= 2'b01;
        end else if (c_valid_d) begin
            re0_i_q <= qpsk_map(c_bits_d[0]);
            re0_q_q <= qpsk_map(c_bits_d[1]);
            re1_i_q <= qpsk_map(c_bits_d[2]);
            re1_q_q <= qpsk_map(c_bits_d[3]);
        end
    end

    assign re0_i = re0_i_q;
    assign re0_q = re0_q_q;
    assign re1_i = re1_i_q;
    assign re1_q = re1_q_q;
`endif

endmodule

// File: tb/tb_nrs_gold_seq.sv
// Bench for nrs_gold_seq: STEPS=1 and STEPS=18 instances against a
// full-sequence Gold reference model.
module tb_nrs_gold_seq;

    localparam int WARM = 1818;
    localparam int RA   = WARM;
    localparam int RB   = WARM / 18;

    typedef struct {
        int         cyc;
        logic [3:0] bits;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] ca = '0, cb = '0;
    logic        va = 1'b0, vb = 1'b0;
    logic [3:0]  cba, cbb;
    logic        cva, cvb, bsa, bsb, pfa, pfb, ofa, ofb;
`ifdef NRS_GOLD_QPSK_OUT_EN
    logic [1:0]  a0i, a0q, a1i, a1q, b0i, b0q, b1i, b1q;
`endif

    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    res_t qa[$], qb[$];
    int   ova[$], ovb[$];
    int   busy_a = 0, busy_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nrs_gold_seq #(.STEPS(1)) dut_a (
        .clk(clk), .rst(rst), .cinit(ca), .cinit_valid(va),
        .c_bits(cba), .c_valid(cva), .busy(bsa), .pend_full(pfa),
`ifdef NRS_GOLD_QPSK_OUT_EN
        .re0_i(a0i), .re0_q(a0q), .re1_i(a1i), .re1_q(a1q),
`endif
        .overflow(ofa)
    );

    nrs_gold_seq #(.STEPS(18)) dut_b (
        .clk(clk), .rst(rst), .cinit(cb), .cinit_valid(vb),
        .c_bits(cbb), .c_valid(cvb), .busy(bsb), .pend_full(pfb),
`ifdef NRS_GOLD_QPSK_OUT_EN
        .re0_i(b0i), .re0_q(b0q), .re1_i(b1i), .re1_q(b1q),
`endif
        .overflow(ofb)
    );

    always @(negedge clk) begin
        if (cva) qa.push_back('{cyc, cba});
        if (cvb) qb.push_back('{cyc, cbb});
        if (ofa) ova.push_back(cyc);
        if (ofb) ovb.push_back(cyc);
        if (bsa) busy_a++;
        if (bsb) busy_b++;
    end

    // Direct evaluation of c(n) = x1(n+Nc) ^ x2(n+Nc) from the recursions.
    function automatic logic [3:0] gold_ref(input logic [27:0] ci);
        logic x1[0:1860];
        logic x2[0:1860];
        logic [3:0] r;
        for (int n = 0; n < 31; n++) begin
            x1[n] = (n == 0);
            x2[n] = (n < 28) ? ci[n] : 1'b0;
        end
        for (int n = 0; n + 31 <= 1851; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int k = 0; k < 4; k++)
            r[k] = x1[1600+218+k] ^ x2[1600+218+k];
        return r;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clr();
        qa.delete(); qb.delete(); ova.delete(); ovb.delete();
        busy_a = 0; busy_b = 0;
    endtask

    function automatic logic [27:0] rnd();
        return 28'($urandom);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        nchk++;
        if ({cba, cva, bsa, pfa, ofa} !== 8'h0) begin
            nerr++;
            $display("FAIL reset_a got=%h want=0", {cba, cva, bsa, pfa, ofa});
        end
        nchk++;
        if ({cbb, cvb, bsb, pfb, ofb} !== 8'h0) begin
            nerr++;
            $display("FAIL reset_b got=%h want=0", {cbb, cvb, bsb, pfb, ofb});
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_single(input logic [27:0] c0);
        int e;
        logic [3:0] w;
        w = gold_ref(c0);
        clr();
        e = cyc + 1;
        ca = c0; cb = c0; va = 1'b1; vb = 1'b1;
        step();
        va = 1'b0; vb = 1'b0;
        step(RA + 10);
        nchk++;
        if (qa.size() !== 1) begin
            nerr++; $display("FAIL single_a_count got=%0d want=1", qa.size());
        end else begin
            nchk++;
            if (qa[0].cyc !== e + RA || qa[0].bits !== w) begin
                nerr++;
                $display("FAIL single_a got=%0d/%h want=%0d/%h",
                         qa[0].cyc - e, qa[0].bits, RA, w);
            end
        end
        nchk++;
        if (busy_a !== RA) begin
            nerr++; $display("FAIL single_busy got=%0d want=%0d", busy_a, RA);
        end
        nchk++;
        if (qb.size() !== 1) begin
            nerr++; $display("FAIL single_b_count got=%0d want=1", qb.size());
        end else begin
            nchk++;
            if (qb[0].cyc !== e + RB || qb[0].bits !== w) begin
                nerr++;
                $display("FAIL single_b got=%0d/%h want=%0d/%h",
                         qb[0].cyc - e, qb[0].bits, RB, w);
            end
        end
    endtask

    task automatic test_back_to_back();
        int e;
        logic [27:0] c[2];
        c[0] = rnd(); c[1] = rnd();
        clr();
        e = cyc + 1;
        ca = c[0]; va = 1'b1;
        step();
        ca = c[1];
        step();
        va = 1'b0;
        nchk++;
        if (pfa !== 1'b1) begin
            nerr++; $display("FAIL b2b_pend got=%b want=1", pfa);
        end
        step(2 * RA + 10);
        nchk++;
        if (qa.size() !== 2) begin
            nerr++; $display("FAIL b2b_count got=%0d want=2", qa.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (qa[i].cyc !== e + (i + 1) * RA || qa[i].bits !== gold_ref(c[i])) begin
                    nerr++;
                    $display("FAIL b2b_res%0d got=%0d/%h want=%0d/%h", i,
                             qa[i].cyc - e, qa[i].bits, (i + 1) * RA, gold_ref(c[i]));
                end
            end
        end
        nchk++;
        if (busy_a !== 2 * RA || ova.size() !== 0) begin
            nerr++;
            $display("FAIL b2b_busy got=%0d/%0d want=%0d/0", busy_a, ova.size(), 2 * RA);
        end
    endtask

    task automatic test_overflow();
        int e;
        logic [27:0] c[3];
        foreach (c[i]) c[i] = rnd();
        clr();
        e = cyc + 1;
        vb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cb = c[i];
            step();
        end
        vb = 1'b0;
        step(4 * RB);
        nchk++;
        if (ovb.size() !== 1) begin
            nerr++; $display("FAIL ovf_count got=%0d want=1", ovb.size());
        end else begin
            nchk++;
            if (ovb[0] !== e + 2) begin
                nerr++; $display("FAIL ovf_edge got=%0d want=2", ovb[0] - e);
            end
        end
        nchk++;
        if (qb.size() !== 2) begin
            nerr++; $display("FAIL ovf_results got=%0d want=2", qb.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (qb[i].cyc !== e + (i + 1) * RB || qb[i].bits !== gold_ref(c[i])) begin
                    nerr++;
                    $display("FAIL ovf_res%0d got=%0d/%h want=%0d/%h", i,
                             qb[i].cyc - e, qb[i].bits, (i + 1) * RB, gold_ref(c[i]));
                end
            end
        end
    endtask

    task automatic test_complete_edge();
        int e;
        logic [27:0] c[3];
        foreach (c[i]) c[i] = rnd();
        clr();
        e = cyc + 1;
        vb = 1'b1; cb = c[0];
        step();
        cb = c[1];
        step();
        vb = 1'b0;
        while (cyc < e + RB - 1) step();
        vb = 1'b1; cb = c[2];
        step();
        vb = 1'b0;
        nchk++;
        if (pfb !== 1'b1 || ofb !== 1'b0) begin
            nerr++; $display("FAIL cedge_pend got=%b%b want=10", pfb, ofb);
        end
        step(3 * RB + 10);
        nchk++;
        if (qb.size() !== 3 || ovb.size() !== 0) begin
            nerr++;
            $display("FAIL cedge_count got=%0d/%0d want=3/0", qb.size(), ovb.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (qb[i].cyc !== e + (i + 1) * RB || qb[i].bits !== gold_ref(c[i])) begin
                    nerr++;
                    $display("FAIL cedge_res%0d got=%0d/%h want=%0d/%h", i,
                             qb[i].cyc - e, qb[i].bits, (i + 1) * RB, gold_ref(c[i]));
                end
            end
        end
    endtask

    task automatic test_direct_reload();
        int e;
        logic [27:0] c[2];
        c[0] = rnd(); c[1] = rnd();
        clr();
        e = cyc + 1;
        vb = 1'b1; cb = c[0];
        step();
        vb = 1'b0;
        while (cyc < e + RB - 1) step();
        vb = 1'b1; cb = c[1];
        step();
        vb = 1'b0;
        step(2 * RB + 10);
        nchk++;
        if (qb.size() !== 2 || busy_b !== 2 * RB) begin
            nerr++;
            $display("FAIL direct_count got=%0d/%0d want=2/%0d", qb.size(), busy_b, 2 * RB);
        end else begin
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (qb[i].cyc !== e + (i + 1) * RB || qb[i].bits !== gold_ref(c[i])) begin
                    nerr++;
                    $display("FAIL direct_res%0d got=%0d/%h want=%0d/%h", i,
                             qb[i].cyc - e, qb[i].bits, (i + 1) * RB, gold_ref(c[i]));
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        int e;
        logic [27:0] c0;
        clr();
        e = cyc + 1;
        va = 1'b1; ca = rnd();
        step();
        ca = rnd();
        step();
        va = 1'b0;
        while (cyc < e + 899) step();
        nchk++;
        if (pfa !== 1'b1 || bsa !== 1'b1) begin
            nerr++; $display("FAIL rstmid_pre got=%b%b want=11", pfa, bsa);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        nchk++;
        if ({cba, cva, bsa, pfa, ofa} !== 8'h0) begin
            nerr++; $display("FAIL rstmid_out got=%h want=0", {cba, cva, bsa, pfa, ofa});
        end
        step(2000);
        nchk++;
        if (qa.size() !== 0) begin
            nerr++; $display("FAIL rstmid_quiet got=%0d want=0", qa.size());
        end
        c0 = rnd();
        clr();
        e = cyc + 1;
        va = 1'b1; ca = c0;
        step();
        va = 1'b0;
        step(RA + 10);
        nchk++;
        if (qa.size() !== 1) begin
            nerr++; $display("FAIL rstmid_fresh_count got=%0d want=1", qa.size());
        end else begin
            nchk++;
            if (qa[0].cyc !== e + RA || qa[0].bits !== gold_ref(c0)) begin
                nerr++;
                $display("FAIL rstmid_fresh got=%0d/%h want=%0d/%h",
                         qa[0].cyc - e, qa[0].bits, RA, gold_ref(c0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(28'd13313);
        test_single(28'd14337);
        test_back_to_back();
        test_overflow();
        test_complete_edge();
        test_direct_reload();
        test_overflow();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
